// File: rtl/exec.sv
// -----------------------------------------------------------------------------
// exec -- EX stage of the five-stage pipeline, registered into EX/MEM.
//
// The ALU operates on operand A (dBusA) and operand B, which is either dBusB
// or dImm32. This stage also works out:
//   - the destination register
//   - the jump-and-link override
//   - the branch/jump target
// Every result is captured in one register stage, so outputs appear one
// cycle after the inputs are sampled.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset (clears outputs)
//   dRegDst             destination select (1: dRd, 0: dRt)
//   dALUSrc             operand B select (1: dImm32, 0: dBusB)
//   dMemToReg, dRegWrite, dMemWr, dBranch, dJump, dJal, dJar
//                       decode-stage controls
//   dAluCtrl[3:0]       ALU operation code
//   dFPoint[1:0], dDsize[1:0], dLoadext
//                       pass-through controls
//   dImm32, dBusA, dBusB, dNextAddress [31:0]
//                       datapath inputs
//   dRd, dRt [4:0]      register numbers
//   MemWr, Branch, MemtoReg, RegWr, Dsize, Zero, ALUout, Rw, Jump,
//   FPoint, Loadext, Jal, BusB, BranchTarget
//                       registered EX/MEM outputs
// -----------------------------------------------------------------------------
module exec #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              dRegDst,
  input  logic              dALUSrc,
  input  logic              dMemToReg,
  input  logic              dRegWrite,
  input  logic              dMemWr,
  input  logic              dBranch,
  input  logic              dJump,
  input  logic [3:0]        dAluCtrl,
  input  logic [1:0]        dFPoint,
  input  logic [1:0]        dDsize,
  input  logic              dLoadext,
  input  logic              dJal,
  input  logic              dJar,
  input  logic [DATA_W-1:0] dImm32,
  input  logic [DATA_W-1:0] dBusA,
  input  logic [DATA_W-1:0] dBusB,
  input  logic [4:0]        dRd,
  input  logic [4:0]        dRt,
  input  logic [DATA_W-1:0] dNextAddress,
  output logic              MemWr,
  output logic              Branch,
  output logic              MemtoReg,
  output logic              RegWr,
  output logic [1:0]        Dsize,
  output logic              Zero,
  output logic [DATA_W-1:0] ALUout,
  output logic [4:0]        Rw,
  output logic              Jump,
  output logic [1:0]        FPoint,
  output logic              Loadext,
  output logic              Jal,
  output logic [DATA_W-1:0] BusB,
  output logic [DATA_W-1:0] BranchTarget
);

  localparam logic [4:0] LINK_REG = 5'd31;

  typedef struct packed {
    logic              mem_wr;
    logic              branch;
    logic              mem_to_reg;
    logic              reg_wr;
    logic [1:0]        dsize;
    logic              zero;
    logic [DATA_W-1:0] alu_out;
    logic [4:0]        rw;
    logic              jump;
    logic [1:0]        fpoint;
    logic              loadext;
    logic              jal;
    logic [DATA_W-1:0] bus_b;
    logic [DATA_W-1:0] branch_target;
  } ex_mem_t;

  // ALU: all arithmetic wraps modulo 2^DATA_W. ADD/ADDU and SUB/SUBU are
  // identical here because overflow is not trapped.
  function automatic logic [DATA_W-1:0] alu_op(
    input logic [3:0]        op,
    input logic [DATA_W-1:0] a,
    input logic [DATA_W-1:0] b
  );
    logic signed [DATA_W-1:0] a_s;
    logic signed [DATA_W-1:0] b_s;
    logic        [4:0]        shamt;
    a_s   = a;
    b_s   = b;
    shamt = b[4:0];
    case (op)
      4'h0, 4'h1: alu_op = a + b;
      4'h2, 4'h3: alu_op = a - b;
      4'h4:       alu_op = a & b;
      4'h5:       alu_op = a | b;
      4'h6:       alu_op = a ^ b;
      4'h7:       alu_op = ~(a | b);
      4'h8:       alu_op = {{(DATA_W-1){1'b0}}, (a_s < b_s)};
      4'h9:       alu_op = {{(DATA_W-1){1'b0}}, (a < b)};
      4'hA:       alu_op = a << shamt;
      4'hB:       alu_op = a >> shamt;
      4'hC:       alu_op = a_s >>> shamt;
      4'hD:       alu_op = b << 16;
      4'hE:       alu_op = a;
      default:    alu_op = b;
    endcase
  endfunction

  ex_mem_t             ex_mem_d;
  ex_mem_t             ex_mem_q;
  logic [DATA_W-1:0]   operand_b;
  logic [DATA_W-1:0]   alu_result;

  always_comb begin
    operand_b  = dALUSrc ? dImm32 : dBusB;
    alu_result = alu_op(dAluCtrl, dBusA, operand_b);

    ex_mem_d            = '0;
    ex_mem_d.mem_wr     = dMemWr;
    ex_mem_d.branch     = dBranch;
    ex_mem_d.mem_to_reg = dMemToReg;
    ex_mem_d.reg_wr     = dRegWrite | dJal;
    ex_mem_d.dsize      = dDsize;
    // Zero is taken from the ALU itself, not from the link-address override.
    ex_mem_d.zero       = (alu_result == '0);
    ex_mem_d.alu_out    = dJal ? dNextAddress : alu_result;
    ex_mem_d.rw         = dJal ? LINK_REG : (dRegDst ? dRd : dRt);
    ex_mem_d.jump       = dJump | dJar;
    ex_mem_d.fpoint     = dFPoint;
    ex_mem_d.loadext    = dLoadext;
    ex_mem_d.jal        = dJal;
    // Store data is always the register operand, never the immediate.
    ex_mem_d.bus_b      = dBusB;
    ex_mem_d.branch_target = dJar ? dBusA : (dNextAddress + (dImm32 << 2));
  end

  // EX -> MEM stage boundary
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_mem_q <= '0;
    end else begin
      ex_mem_q <= ex_mem_d;
    end
  end

  assign MemWr        = ex_mem_q.mem_wr;
  assign Branch       = ex_mem_q.branch;
  assign MemtoReg     = ex_mem_q.mem_to_reg;
  assign RegWr        = ex_mem_q.reg_wr;
  assign Dsize        = ex_mem_q.dsize;
  assign Zero         = ex_mem_q.zero;
  assign ALUout       = ex_mem_q.alu_out;
  assign Rw           = ex_mem_q.rw;
  assign Jump         = ex_mem_q.jump;
  assign FPoint       = ex_mem_q.fpoint;
  assign Loadext      = ex_mem_q.loadext;
  assign Jal          = ex_mem_q.jal;
  assign BusB         = ex_mem_q.bus_b;
  assign BranchTarget = ex_mem_q.branch_target;

endmodule

// File: tb/tb_exec.sv
// -----------------------------------------------------------------------------
// tb_exec -- directed testbench for exec (EX/MEM stage).
// -----------------------------------------------------------------------------
module tb_exec;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        dRegDst, dALUSrc, dMemToReg, dRegWrite, dMemWr, dBranch, dJump;
  logic [3:0]  dAluCtrl;
  logic [1:0]  dFPoint, dDsize;
  logic        dLoadext, dJal, dJar;
  logic [31:0] dImm32, dBusA, dBusB, dNextAddress;
  logic [4:0]  dRd, dRt;
  logic        MemWr, Branch, MemtoReg, RegWr, Zero, Jump, Loadext, Jal;
  logic [1:0]  Dsize, FPoint;
  logic [31:0] ALUout, BusB, BranchTarget;
  logic [4:0]  Rw;

  int pass_cnt  = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  exec dut (
    .clk(clk), .rst_n(rst_n),
    .dRegDst(dRegDst), .dALUSrc(dALUSrc), .dMemToReg(dMemToReg),
    .dRegWrite(dRegWrite), .dMemWr(dMemWr), .dBranch(dBranch), .dJump(dJump),
    .dAluCtrl(dAluCtrl), .dFPoint(dFPoint), .dDsize(dDsize),
    .dLoadext(dLoadext), .dJal(dJal), .dJar(dJar), .dImm32(dImm32),
    .dBusA(dBusA), .dBusB(dBusB), .dRd(dRd), .dRt(dRt),
    .dNextAddress(dNextAddress),
    .MemWr(MemWr), .Branch(Branch), .MemtoReg(MemtoReg), .RegWr(RegWr),
    .Dsize(Dsize), .Zero(Zero), .ALUout(ALUout), .Rw(Rw), .Jump(Jump),
    .FPoint(FPoint), .Loadext(Loadext), .Jal(Jal), .BusB(BusB),
    .BranchTarget(BranchTarget)
  );

  task automatic clear_inputs();
    dRegDst = 0; dALUSrc = 0; dMemToReg = 0; dRegWrite = 0; dMemWr = 0;
    dBranch = 0; dJump = 0; dAluCtrl = 0; dFPoint = 0; dDsize = 0;
    dLoadext = 0; dJal = 0; dJar = 0; dImm32 = 0; dBusA = 0; dBusB = 0;
    dRd = 0; dRt = 0; dNextAddress = 0;
  endtask

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    clear_inputs();
    tick();
    total_cnt++;
    if ({MemWr, Branch, MemtoReg, RegWr, Dsize, Zero, ALUout, Rw, Jump, FPoint,
         Loadext, Jal, BusB, BranchTarget} !== '0)
      $display("FAIL reset_initial outputs not zero: ALUout=%h Rw=%0d", ALUout, Rw);
    else pass_cnt++;

    rst_n = 1'b1;
    dALUSrc = 0; dBusA = 32'd5; dBusB = 32'd7; dAluCtrl = 4'd0; dRegDst = 1;
    dRd = 5'd3; dMemWr = 1; dDsize = 2'd2; dNextAddress = 32'h40; dImm32 = 32'd1;
    tick();
    total_cnt++;
    if (ALUout !== 32'd12 || MemWr !== 1'b1 || Dsize !== 2'd2 || BranchTarget !== 32'h44)
      $display("FAIL reset_release_capture ALUout=%h MemWr=%b Dsize=%0d BT=%h, need 0000000c 1 2 00000044",
               ALUout, MemWr, Dsize, BranchTarget);
    else pass_cnt++;

    // Assert reset away from any clock edge: outputs must clear immediately.
    #1 rst_n = 1'b0;
    #1;
    total_cnt++;
    if ({MemWr, Branch, MemtoReg, RegWr, Dsize, Zero, ALUout, Rw, Jump, FPoint,
         Loadext, Jal, BusB, BranchTarget} !== '0)
      $display("FAIL reset_async outputs not cleared mid-cycle: ALUout=%h BusB=%h", ALUout, BusB);
    else pass_cnt++;
    #1 rst_n = 1'b1;
    tick();
    total_cnt++;
    if (ALUout !== 32'd12 || Rw !== 5'd3 || BusB !== 32'd7)
      $display("FAIL reset_recover ALUout=%h Rw=%0d BusB=%h, need 0000000c 3 00000007",
               ALUout, Rw, BusB);
    else pass_cnt++;
  endtask

  task automatic test_add();
    clear_inputs();
    dALUSrc = 0; dBusA = 32'd5; dBusB = 32'd7; dAluCtrl = 4'd0; dRegDst = 1; dRd = 5'd3;
    dRt = 5'd9;
    tick();
    total_cnt++;
    if (ALUout !== 32'd12 || Rw !== 5'd3 || Zero !== 1'b0 || BusB !== 32'd7)
      $display("FAIL add ALUout=%h Rw=%0d Zero=%b BusB=%h, need 0000000c 3 0 00000007",
               ALUout, Rw, Zero, BusB);
    else pass_cnt++;
    dRegDst = 0;
    tick();
    total_cnt++;
    if (Rw !== 5'd9)
      $display("FAIL regdst_rt Rw=%0d need 9", Rw);
    else pass_cnt++;
  endtask

  task automatic test_branch();
    clear_inputs();
    dAluCtrl = 4'd2; dBusA = 32'd9; dBusB = 32'd9; dBranch = 1;
    dNextAddress = 32'h100; dImm32 = 32'd4;
    tick();
    total_cnt++;
    if (Zero !== 1'b1 || Branch !== 1'b1 || BranchTarget !== 32'h110 || ALUout !== 32'd0)
      $display("FAIL branch_sub Zero=%b Branch=%b BT=%h ALUout=%h, need 1 1 00000110 00000000",
               Zero, Branch, BranchTarget, ALUout);
    else pass_cnt++;
    dImm32 = 32'hFFFF_FFFF;  // backward branch by one word
    tick();
    total_cnt++;
    if (BranchTarget !== 32'hFC)
      $display("FAIL branch_backward BT=%h need 000000fc", BranchTarget);
    else pass_cnt++;
  endtask

  task automatic test_imm_wrap();
    clear_inputs();
    dALUSrc = 1; dImm32 = 32'hFFFF_FFFF; dBusA = 32'd1; dAluCtrl = 4'd0; dBusB = 32'h55;
    tick();
    total_cnt++;
    if (ALUout !== 32'd0 || Zero !== 1'b1 || BusB !== 32'h55)
      $display("FAIL imm_wrap ALUout=%h Zero=%b BusB=%h, need 00000000 1 00000055",
               ALUout, Zero, BusB);
    else pass_cnt++;
  endtask

  task automatic test_alu_ops();
    logic [3:0]  ops [14] = '{4'h1, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8, 4'h9,
                              4'hA, 4'hB, 4'hC, 4'hD, 4'hE, 4'hF};
    logic [31:0] av  [14] = '{32'hFFFF_FFFF, 32'd3, 32'hF0F0, 32'hF0F0, 32'hFFFF, 32'd0,
                              32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, 32'h8000_0000,
                              32'h8000_0000, 32'd7, 32'hDEAD_BEEF, 32'd1};
    logic [31:0] bv  [14] = '{32'd2, 32'd5, 32'hFF00, 32'h0F0F, 32'h0F0F, 32'd0,
                              32'd1, 32'd1, 32'h24, 32'd4, 32'd4, 32'h1234, 32'd3,
                              32'hCAFE_BABE};
    logic [31:0] ev  [14] = '{32'd1, 32'hFFFF_FFFE, 32'hF000, 32'hFFFF, 32'hF0F0,
                              32'hFFFF_FFFF, 32'd1, 32'd0, 32'h10, 32'h0800_0000,
                              32'hF800_0000, 32'h1234_0000, 32'hDEAD_BEEF,
                              32'hCAFE_BABE};
    clear_inputs();
    for (int i = 0; i < 14; i++) begin
      dAluCtrl = ops[i]; dBusA = av[i]; dBusB = bv[i];
      tick();
      total_cnt++;
      if (ALUout !== ev[i] || Zero !== (ev[i] == 32'd0))
        $display("FAIL alu_op_%h ALUout=%h Zero=%b, need %h %b",
                 ops[i], ALUout, Zero, ev[i], (ev[i] == 32'd0));
      else pass_cnt++;
    end
  endtask

  task automatic test_jal_jar();
    clear_inputs();
    dJal = 1; dRegWrite = 0; dNextAddress = 32'h200; dRegDst = 1; dRd = 5'd3;
    dBusA = 32'd0; dBusB = 32'd0; dAluCtrl = 4'd0;
    tick();
    total_cnt++;
    if (Rw !== 5'd31 || ALUout !== 32'h200 || RegWr !== 1'b1 || Jal !== 1'b1 || Zero !== 1'b1)
      $display("FAIL jal Rw=%0d ALUout=%h RegWr=%b Jal=%b Zero=%b, need 31 00000200 1 1 1",
               Rw, ALUout, RegWr, Jal, Zero);
    else pass_cnt++;

    clear_inputs();
    dJar = 1; dBusA = 32'h3000; dRt = 5'd7; dNextAddress = 32'h80; dImm32 = 32'd1;
    tick();
    total_cnt++;
    if (BranchTarget !== 32'h3000 || Jump !== 1'b1 || Rw !== 5'd7 || RegWr !== 1'b0)
      $display("FAIL jar BT=%h Jump=%b Rw=%0d RegWr=%b, need 00003000 1 7 0",
               BranchTarget, Jump, Rw, RegWr);
    else pass_cnt++;

    dJal = 1;
    tick();
    total_cnt++;
    if (BranchTarget !== 32'h3000 || Rw !== 5'd31 || ALUout !== 32'h80 || Jump !== 1'b1)
      $display("FAIL jal_jar BT=%h Rw=%0d ALUout=%h Jump=%b, need 00003000 31 00000080 1",
               BranchTarget, Rw, ALUout, Jump);
    else pass_cnt++;
  endtask

  task automatic test_control_sweep();
    clear_inputs();
    tick();
    dMemToReg = 1; dRegWrite = 1; dMemWr = 1; dBranch = 1; dJump = 1;
    dFPoint = 2'd3; dDsize = 2'd3; dLoadext = 1;
    #1;
    total_cnt++;
    if ({MemWr, Branch, MemtoReg, RegWr, Jump, FPoint, Dsize, Loadext} !== 10'd0)
      $display("FAIL ctrl_before_edge outputs=%b need 0000000000",
               {MemWr, Branch, MemtoReg, RegWr, Jump, FPoint, Dsize, Loadext});
    else pass_cnt++;
    tick();
    total_cnt++;
    if ({MemWr, Branch, MemtoReg, RegWr, Jump, FPoint, Dsize, Loadext} !== 10'h3FF)
      $display("FAIL ctrl_all_ones outputs=%b need 1111111111",
               {MemWr, Branch, MemtoReg, RegWr, Jump, FPoint, Dsize, Loadext});
    else pass_cnt++;
    clear_inputs();
    tick();
    total_cnt++;
    if ({MemWr, Branch, MemtoReg, RegWr, Jump, FPoint, Dsize, Loadext, Jal} !== 11'd0)
      $display("FAIL ctrl_all_zero outputs=%b need 00000000000",
               {MemWr, Branch, MemtoReg, RegWr, Jump, FPoint, Dsize, Loadext, Jal});
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_add();
    test_branch();
    test_imm_wrap();
    test_alu_ops();
    test_jal_jar();
    test_control_sweep();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/exec.md
EXEC -- requirements
Module: exec
Interface
REQ-001 clk  in  1  single clock; all registered state updates on rising edge.
REQ-002 rst_n  in  1  reset, asynchronous and active-low.
REQ-003 dRegDst  in  1  destination select: 1 = dRd, 0 = dRt.
REQ-004 dALUSrc  in  1  ALU operand B select: 1 = dImm32, 0 = dBusB.
REQ-005 dMemToReg  in  1  writeback-from-memory control, passed to MemtoReg.
REQ-006 dRegWrite  in  1  register-write control.
REQ-007 dMemWr  in  1  memory-write control.
REQ-008 dBranch  in  1  conditional-branch control.
REQ-009 dJump  in  1  jump control.
REQ-010 dAluCtrl  in  4  ALU operation code.
REQ-011 dFPoint  in  2  floating-point control, pass-through.
REQ-012 dDsize  in  2  memory data size, pass-through.
REQ-013 dLoadext  in  1  load sign-extend control, pass-through.
REQ-014 dJal  in  1  jump-and-link.
REQ-015 dJar  in  1  jump-to-register.
REQ-016 dImm32  in  32  extended immediate.
REQ-017 dBusA  in  32  register operand A.
REQ-018 dBusB  in  32  register operand B.
REQ-019 dRd  in  5  rd register number.
REQ-020 dRt  in  5  rt register number.
REQ-021 dNextAddress  in  32  PC+4 of the instruction.
REQ-022 MemWr  out  1  registered dMemWr.
REQ-023 Branch  out  1  registered dBranch.
REQ-024 MemtoReg  out  1  registered dMemToReg.
REQ-025 RegWr  out  1  registered (dRegWrite | dJal).
REQ-026 Dsize  out  2  registered dDsize.
REQ-027 Zero  out  1  registered (ALU result == 0).
REQ-028 ALUout  out  32  registered result (link address when dJal).
REQ-029 Rw  out  5  registered destination register.
REQ-030 Jump  out  1  registered (dJump | dJar).
REQ-031 FPoint  out  2  registered dFPoint.
REQ-032 Loadext  out  1  registered dLoadext.
REQ-033 Jal  out  1  registered dJal.
REQ-034 BusB  out  32  registered dBusB (store data; never the immediate).
REQ-035 BranchTarget  out  32  registered branch/jump target.
Function
REQ-036 All outputs SHALL be registered in one EX/MEM stage: inputs sampled at rising clk appear on outputs after that edge, 1-cycle latency, no stall/flush inputs.
REQ-037 Operand B SHALL be dALUSrc ? dImm32 : dBusB; operand A SHALL be dBusA; all arithmetic 32-bit modulo 2^32 with overflow ignored.
REQ-038 dAluCtrl SHALL decode: 0 ADD, 1 ADDU, 2 SUB, 3 SUBU, 4 AND, 5 OR, 6 XOR, 7 NOR, 8 SLT (signed, result 0/1), 9 SLTU, A SLL, B SRL, C SRA (A shifted by B[4:0]), D LHI (B<<16), E pass A, F pass B.
REQ-039 Zero SHALL reflect the ALU operation result, computed before any Jal override.
REQ-040 Rw SHALL be 31 when dJal, else dRegDst ? dRd : dRt; ALUout SHALL be dNextAddress when dJal, else the ALU result.
REQ-041 BranchTarget SHALL be dBusA when dJar, else dNextAddress + (dImm32 << 2), truncated to 32 bits.
REQ-042 Simultaneous dJal and dJar SHALL apply both rules: link to r31 and target dBusA.
Reset
REQ-043 While rst_n is low, every output SHALL be 0 immediately, regardless of clk; the first rising edge after rst_n goes high captures inputs normally.
Verification
REQ-044 rst_n=0 mid-cycle with nonzero inputs -> all outputs 0 without waiting for a clk edge; rst_n=1, then edge -> outputs track inputs.
REQ-045 dALUSrc=0, dBusA=5, dBusB=7, dAluCtrl=0, dRegDst=1, dRd=3 -> next edge: ALUout=12, Rw=3, Zero=0, BusB=7.
REQ-046 dAluCtrl=2, dBusA=dBusB=9, dBranch=1, dNextAddress=0x100, dImm32=4 -> Zero=1, Branch=1, BranchTarget=0x110; dALUSrc=1, dImm32=0xFFFFFFFF, dBusA=1, dAluCtrl=0 -> ALUout=0, Zero=1.
REQ-047 dJal=1, dRegWrite=0, dNextAddress=0x200 -> Rw=31, ALUout=0x200, RegWr=1, Jal=1; dJar=1, dBusA=0x3000 -> BranchTarget=0x3000, Jump=1; control sweep (all 1 then all 0) -> each control output follows one edge later.
